// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: control sequencer for the multi-cycle lab CPU.
// It steps PC, IR, register file, ALU, MDR/ALUOut and the shared memory
// through FETCH/DECODE/execute/writeback. It decodes op/funct, waits on
// memory, and resolves branches from the datapath compare flags.
//
// Optional build macro: MC_CTRL_PERF_EN adds cycle_cnt_o / instr_cnt_o.
//
// Opcode map (MIPS-style): R-type 00, bgez 01, j 02, jal 03, beq 04,
// bnez 05, bgt 07, addi 08, ori 0d, lui 0f, lw 23, sw 2b.
// Legal R-type funct: sll 00, srl 02, sllv 04, srlv 06, jr 08, mul 18,
// add 20, sub 22, and 24, or 25, slt 2a.

module mc_ctrl_fsm #(
    parameter int ST_W  = 4,
    parameter int CNT_W = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [5:0]      op_i,
    input  logic [5:0]      funct_i,
    input  logic            mem_ready_i,
    input  logic            eq_i,
    input  logic            gt_i,
    input  logic            rs_zero_i,
    input  logic            rs_neg_i,
    output logic            pc_write_o,
    output logic [1:0]      pc_src_o,
    output logic            iord_o,
    output logic            mem_read_o,
    output logic            mem_write_o,
    output logic            ir_write_o,
    output logic            reg_write_o,
    output logic [1:0]      reg_dst_o,
    output logic [1:0]      mem_to_reg_o,
    output logic [1:0]      alu_src_a_o,
    output logic [2:0]      alu_src_b_o,
    output logic [1:0]      alu_op_o,
    output logic            instr_done_o,
    output logic            illegal_o,
    output logic [ST_W-1:0] state_o
`ifdef MC_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt_o,
    output logic [CNT_W-1:0] instr_cnt_o
`endif
);

    // Elaboration-time sanity on the parameters.
    if (ST_W < 4) begin : g_bad_st_w
        $error("mc_ctrl_fsm: ST_W must be at least 4");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("mc_ctrl_fsm: CNT_W must be at least 1");
    end

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BGEZ  = 6'h01;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNEZ  = 6'h05;
    localparam logic [5:0] OP_BGT   = 6'h07;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    // R-type funct codes
    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SLLV  = 6'h04;
    localparam logic [5:0] FN_SRLV  = 6'h06;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_MUL   = 6'h18;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2a;

    // Mux select encodings
    localparam logic [1:0] PC_ALU    = 2'd0;
    localparam logic [1:0] PC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_JTGT   = 2'd2;
    localparam logic [1:0] PC_REGA   = 2'd3;

    localparam logic [1:0] DST_RT    = 2'd0;
    localparam logic [1:0] DST_RD    = 2'd1;
    localparam logic [1:0] DST_RA    = 2'd2;

    localparam logic [1:0] WD_ALUOUT = 2'd0;
    localparam logic [1:0] WD_MDR    = 2'd1;
    localparam logic [1:0] WD_PC     = 2'd2;

    localparam logic [1:0] A_PC      = 2'd0;
    localparam logic [1:0] A_REGA    = 2'd1;
    localparam logic [1:0] A_ZERO    = 2'd2;

    localparam logic [2:0] B_REGB    = 3'd0;
    localparam logic [2:0] B_FOUR    = 3'd1;
    localparam logic [2:0] B_SEXT    = 3'd2;
    localparam logic [2:0] B_SEXT_SH = 3'd3;
    localparam logic [2:0] B_ZEXT    = 3'd4;
    localparam logic [2:0] B_UPPER   = 3'd5;

    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_SUB   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;
    localparam logic [1:0] ALU_OR    = 2'd3;

    typedef enum logic [ST_W-1:0] {
        S_FETCH    = 'd0,
        S_DECODE   = 'd1,
        S_MEM_ADDR = 'd2,
        S_MEM_RD   = 'd3,
        S_MEM_WB   = 'd4,
        S_MEM_WR   = 'd5,
        S_EXEC_R   = 'd6,
        S_R_WB     = 'd7,
        S_EXEC_I   = 'd8,
        S_I_WB     = 'd9,
        S_BRANCH   = 'd10,
        S_JUMP     = 'd11,
        S_JAL      = 'd12,
        S_JR       = 'd13,
        S_TRAP     = 'd14,
        S_SPARE    = 'd15
    } state_t;

    state_t state;
    logic   branch_taken;

    // True for every R-type funct the datapath implements except jr.
    function automatic logic r_funct_legal(input logic [5:0] fn);
        case (fn)
            FN_SLL, FN_SRL, FN_SLLV, FN_SRLV, FN_MUL,
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: r_funct_legal = 1'b1;
            default:                              r_funct_legal = 1'b0;
        endcase
    endfunction

    // DECODE dispatch target from the opcode held in IR.
    function automatic state_t dispatch(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            OP_LW, OP_SW:                     dispatch = S_MEM_ADDR;
            OP_RTYPE: begin
                if (fn == FN_JR)              dispatch = S_JR;
                else if (r_funct_legal(fn))   dispatch = S_EXEC_R;
                else                          dispatch = S_TRAP;
            end
            OP_ADDI, OP_ORI, OP_LUI:          dispatch = S_EXEC_I;
            OP_BEQ, OP_BGT, OP_BNEZ, OP_BGEZ: dispatch = S_BRANCH;
            OP_J:                             dispatch = S_JUMP;
            OP_JAL:                           dispatch = S_JAL;
            default:                          dispatch = S_TRAP;
        endcase
    endfunction

    // State register with next-state selection; reset wins over everything.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of block ordering in simulation.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= S_FETCH;
        end else begin
            case (state)
                S_FETCH:    if (mem_ready_i) state <= S_DECODE;
                S_DECODE:   state <= dispatch(op_i, funct_i);
                S_MEM_ADDR: state <= (op_i == OP_LW) ? S_MEM_RD : S_MEM_WR;
                S_MEM_RD:   if (mem_ready_i) state <= S_MEM_WB;
                S_MEM_WR:   if (mem_ready_i) state <= S_FETCH;
                S_EXEC_R:   state <= S_R_WB;
                S_EXEC_I:   state <= S_I_WB;
                S_TRAP:     state <= S_TRAP;
                // MEM_WB, R_WB, I_WB, BRANCH, JUMP, JAL, JR and the spare
                // encoding all finish here and return to FETCH.
                default:    state <= S_FETCH;
            endcase
        end
    end

    // Branch condition selected by the opcode of the branch in IR.
    // NOTE: every always_comb output gets a default first so no path
    // through the case leaves it unassigned and infers a latch.
    always_comb begin
        branch_taken = 1'b0;
        case (op_i)
            OP_BEQ:  branch_taken = eq_i;
            OP_BGT:  branch_taken = gt_i;
            OP_BNEZ: branch_taken = !rs_zero_i;
            OP_BGEZ: branch_taken = !rs_neg_i;
            default: branch_taken = 1'b0;
        endcase
    end

    // Control outputs decoded from state, mem_ready_i and the branch flags;
    // all forced to zero while reset is held so nothing partial is written.
    always_comb begin
        pc_write_o   = 1'b0;
        pc_src_o     = PC_ALU;
        iord_o       = 1'b0;
        mem_read_o   = 1'b0;
        mem_write_o  = 1'b0;
        ir_write_o   = 1'b0;
        reg_write_o  = 1'b0;
        reg_dst_o    = DST_RT;
        mem_to_reg_o = WD_ALUOUT;
        alu_src_a_o  = A_PC;
        alu_src_b_o  = B_REGB;
        alu_op_o     = ALU_ADD;
        instr_done_o = 1'b0;
        illegal_o    = 1'b0;
        if (!rst_i) begin
            case (state)
                S_FETCH: begin
                    mem_read_o  = 1'b1;
                    alu_src_a_o = A_PC;
                    alu_src_b_o = B_FOUR;
                    alu_op_o    = ALU_ADD;
                    if (mem_ready_i) begin
                        ir_write_o = 1'b1;
                        pc_write_o = 1'b1;
                        pc_src_o   = PC_ALU;
                    end
                end
                S_DECODE: begin
                    alu_src_a_o = A_PC;
                    alu_src_b_o = B_SEXT_SH;
                    alu_op_o    = ALU_ADD;
                end
                S_MEM_ADDR: begin
                    alu_src_a_o = A_REGA;
                    alu_src_b_o = B_SEXT;
                    alu_op_o    = ALU_ADD;
                end
                S_MEM_RD: begin
                    mem_read_o = 1'b1;
                    iord_o     = 1'b1;
                end
                S_MEM_WB: begin
                    reg_write_o  = 1'b1;
                    reg_dst_o    = DST_RT;
                    mem_to_reg_o = WD_MDR;
                    instr_done_o = 1'b1;
                end
                S_MEM_WR: begin
                    mem_write_o  = 1'b1;
                    iord_o       = 1'b1;
                    instr_done_o = mem_ready_i;
                end
                S_EXEC_R: begin
                    alu_src_a_o = A_REGA;
                    alu_src_b_o = B_REGB;
                    alu_op_o    = ALU_FUNCT;
                end
                S_R_WB: begin
                    reg_write_o  = 1'b1;
                    reg_dst_o    = DST_RD;
                    mem_to_reg_o = WD_ALUOUT;
                    instr_done_o = 1'b1;
                end
                S_EXEC_I: begin
                    case (op_i)
                        OP_ORI: begin
                            alu_src_a_o = A_REGA;
                            alu_src_b_o = B_ZEXT;
                            alu_op_o    = ALU_OR;
                        end
                        OP_LUI: begin
                            alu_src_a_o = A_ZERO;
                            alu_src_b_o = B_UPPER;
                            alu_op_o    = ALU_OR;
                        end
                        default: begin
                            alu_src_a_o = A_REGA;
                            alu_src_b_o = B_SEXT;
                            alu_op_o    = ALU_ADD;
                        end
                    endcase
                end
                S_I_WB: begin
                    reg_write_o  = 1'b1;
                    reg_dst_o    = DST_RT;
                    mem_to_reg_o = WD_ALUOUT;
                    instr_done_o = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a_o  = A_REGA;
                    alu_src_b_o  = B_REGB;
                    alu_op_o     = ALU_SUB;
                    instr_done_o = 1'b1;
                    if (branch_taken) begin
                        pc_write_o = 1'b1;
                        pc_src_o   = PC_ALUOUT;
                    end
                end
                S_JUMP: begin
                    pc_write_o   = 1'b1;
                    pc_src_o     = PC_JTGT;
                    instr_done_o = 1'b1;
                end
                S_JAL: begin
                    // PC already holds PC+4 from FETCH, so it is the link value.
                    reg_write_o  = 1'b1;
                    reg_dst_o    = DST_RA;
                    mem_to_reg_o = WD_PC;
                    pc_write_o   = 1'b1;
                    pc_src_o     = PC_JTGT;
                    instr_done_o = 1'b1;
                end
                S_JR: begin
                    pc_write_o   = 1'b1;
                    pc_src_o     = PC_REGA;
                    instr_done_o = 1'b1;
                end
                default: begin
                    // TRAP and the spare encoding: flag only, no writes.
                    illegal_o = 1'b1;
                end
            endcase
        end
    end

    assign state_o = state;

`ifdef MC_CTRL_PERF_EN
    // Free-running cycle and retired-instruction counters, wrapping.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cycle_cnt_o <= '0;
            instr_cnt_o <= '0;
        end else begin
            cycle_cnt_o <= cycle_cnt_o + 1'b1;
            if (instr_done_o) instr_cnt_o <= instr_cnt_o + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: directed self-checking bench for mc_ctrl_fsm.
// Each step sets inputs just after a rising edge, checks state and the
// full control word mid-cycle, then advances one clock.

module tb_mc_ctrl_fsm;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [5:0]  op_i;
    logic [5:0]  funct_i;
    logic        mem_ready_i;
    logic        eq_i;
    logic        gt_i;
    logic        rs_zero_i;
    logic        rs_neg_i;
    logic        pc_write_o;
    logic [1:0]  pc_src_o;
    logic        iord_o;
    logic        mem_read_o;
    logic        mem_write_o;
    logic        ir_write_o;
    logic        reg_write_o;
    logic [1:0]  reg_dst_o;
    logic [1:0]  mem_to_reg_o;
    logic [1:0]  alu_src_a_o;
    logic [2:0]  alu_src_b_o;
    logic [1:0]  alu_op_o;
    logic        instr_done_o;
    logic        illegal_o;
    logic [3:0]  state_o;
`ifdef MC_CTRL_PERF_EN
    logic [31:0] cycle_cnt_o;
    logic [31:0] instr_cnt_o;
`endif

    int n_checks = 0;
    int n_errors = 0;

    mc_ctrl_fsm #(.ST_W(4), .CNT_W(32)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .op_i         (op_i),
        .funct_i      (funct_i),
        .mem_ready_i  (mem_ready_i),
        .eq_i         (eq_i),
        .gt_i         (gt_i),
        .rs_zero_i    (rs_zero_i),
        .rs_neg_i     (rs_neg_i),
        .pc_write_o   (pc_write_o),
        .pc_src_o     (pc_src_o),
        .iord_o       (iord_o),
        .mem_read_o   (mem_read_o),
        .mem_write_o  (mem_write_o),
        .ir_write_o   (ir_write_o),
        .reg_write_o  (reg_write_o),
        .reg_dst_o    (reg_dst_o),
        .mem_to_reg_o (mem_to_reg_o),
        .alu_src_a_o  (alu_src_a_o),
        .alu_src_b_o  (alu_src_b_o),
        .alu_op_o     (alu_op_o),
        .instr_done_o (instr_done_o),
        .illegal_o    (illegal_o),
        .state_o      (state_o)
`ifdef MC_CTRL_PERF_EN
        ,
        .cycle_cnt_o  (cycle_cnt_o),
        .instr_cnt_o  (instr_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    // Control word, field order:
    // pcw pcsrc iord mrd mwr irw rw rdst m2r srcA srcB aluop done ill
    logic [20:0] obs_ctl;
    assign obs_ctl = {pc_write_o, pc_src_o, iord_o, mem_read_o, mem_write_o,
                      ir_write_o, reg_write_o, reg_dst_o, mem_to_reg_o,
                      alu_src_a_o, alu_src_b_o, alu_op_o, instr_done_o, illegal_o};

    function automatic logic [20:0] ctl(
        input logic pcw, input logic [1:0] pcs, input logic iord,
        input logic mr, input logic mw, input logic irw, input logic rw,
        input logic [1:0] rd, input logic [1:0] m2r, input logic [1:0] a,
        input logic [2:0] b, input logic [1:0] op, input logic done,
        input logic ill);
        ctl = {pcw, pcs, iord, mr, mw, irw, rw, rd, m2r, a, b, op, done, ill};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check state and control word mid-cycle, then advance.
    task automatic cyc(input string tag, input logic [3:0] st, input logic [20:0] exp_ctl);
        #1;
        check({tag, ".state"}, {28'd0, state_o}, {28'd0, st});
        check({tag, ".ctl"}, {11'd0, obs_ctl}, {11'd0, exp_ctl});
        @(posedge clk_i);
        #1;
    endtask

    logic [20:0] z;
    logic [20:0] fetch_go;
    logic [20:0] decode_c;

    initial begin
        z        = ctl(0,0,0,0,0,0,0,0,0,0,0,0,0,0);
        fetch_go = ctl(1,0,0,1,0,1,0,0,0,0,1,0,0,0);
        decode_c = ctl(0,0,0,0,0,0,0,0,0,0,3,0,0,0);

        rst_i = 1'b1; op_i = 6'h00; funct_i = 6'h20; mem_ready_i = 1'b1;
        eq_i = 1'b0; gt_i = 1'b0; rs_zero_i = 1'b0; rs_neg_i = 1'b0;

        // Reset held for three edges; outputs quiet even with mem_ready high.
        @(posedge clk_i);
        #1;
        cyc("rst_a", 4'd0, z);
        cyc("rst_b", 4'd0, z);
        rst_i = 1'b0;

        // add $3,$1,$2: 0,1,6,7 then back to 0
        op_i = 6'h00; funct_i = 6'h20;
        cyc("add_fetch",  4'd0, fetch_go);
        cyc("add_decode", 4'd1, decode_c);
        cyc("add_exec",   4'd6, ctl(0,0,0,0,0,0,0,0,0,1,0,2,0,0));
        cyc("add_wb",     4'd7, ctl(0,0,0,0,0,0,1,1,0,0,0,0,1,0));

        // lw with two wait states in MEM_RD: 7 cycles
        op_i = 6'h23;
        cyc("lw_fetch",   4'd0, fetch_go);
        cyc("lw_decode",  4'd1, decode_c);
        cyc("lw_addr",    4'd2, ctl(0,0,0,0,0,0,0,0,0,1,2,0,0,0));
        mem_ready_i = 1'b0;
        cyc("lw_rd_w1",   4'd3, ctl(0,0,1,1,0,0,0,0,0,0,0,0,0,0));
        cyc("lw_rd_w2",   4'd3, ctl(0,0,1,1,0,0,0,0,0,0,0,0,0,0));
        mem_ready_i = 1'b1;
        cyc("lw_rd_go",   4'd3, ctl(0,0,1,1,0,0,0,0,0,0,0,0,0,0));
        cyc("lw_wb",      4'd4, ctl(0,0,0,0,0,0,1,0,1,0,0,0,1,0));

        // beq taken, then not taken
        op_i = 6'h04; eq_i = 1'b1;
        cyc("beq_t_fetch",  4'd0, fetch_go);
        cyc("beq_t_decode", 4'd1, decode_c);
        cyc("beq_t_br",     4'd10, ctl(1,1,0,0,0,0,0,0,0,1,0,1,1,0));
        eq_i = 1'b0; gt_i = 1'b1;
        cyc("beq_n_fetch",  4'd0, fetch_go);
        cyc("beq_n_decode", 4'd1, decode_c);
        cyc("beq_n_br",     4'd10, ctl(0,0,0,0,0,0,0,0,0,1,0,1,1,0));

        // bgez with a negative rs: not taken despite eq/gt high
        op_i = 6'h01; eq_i = 1'b1; gt_i = 1'b1; rs_neg_i = 1'b1;
        cyc("bgez_fetch",  4'd0, fetch_go);
        cyc("bgez_decode", 4'd1, decode_c);
        cyc("bgez_br",     4'd10, ctl(0,0,0,0,0,0,0,0,0,1,0,1,1,0));

        // bgt with gt high: taken even though eq is low and rs is negative
        op_i = 6'h07; eq_i = 1'b0; gt_i = 1'b1;
        cyc("bgt_fetch",   4'd0, fetch_go);
        cyc("bgt_decode",  4'd1, decode_c);
        cyc("bgt_br",      4'd10, ctl(1,1,0,0,0,0,0,0,0,1,0,1,1,0));

        // bnez with rs nonzero: taken
        op_i = 6'h05; gt_i = 1'b0; rs_zero_i = 1'b0; rs_neg_i = 1'b0;
        cyc("bnez_fetch",  4'd0, fetch_go);
        cyc("bnez_decode", 4'd1, decode_c);
        cyc("bnez_br",     4'd10, ctl(1,1,0,0,0,0,0,0,0,1,0,1,1,0));

        // jal: link and jump in a single cycle
        op_i = 6'h03;
        cyc("jal_fetch",   4'd0, fetch_go);
        cyc("jal_decode",  4'd1, decode_c);
        cyc("jal_exec",    4'd12, ctl(1,2,0,0,0,0,1,2,2,0,0,0,1,0));

        // j
        op_i = 6'h02;
        cyc("j_fetch",     4'd0, fetch_go);
        cyc("j_decode",    4'd1, decode_c);
        cyc("j_exec",      4'd11, ctl(1,2,0,0,0,0,0,0,0,0,0,0,1,0));

        // jr
        op_i = 6'h00; funct_i = 6'h08;
        cyc("jr_fetch",    4'd0, fetch_go);
        cyc("jr_decode",   4'd1, decode_c);
        cyc("jr_exec",     4'd13, ctl(1,3,0,0,0,0,0,0,0,0,0,0,1,0));

        // lui with one fetch wait state
        op_i = 6'h0f; mem_ready_i = 1'b0;
        cyc("lui_fetch_w", 4'd0, ctl(0,0,0,1,0,0,0,0,0,0,1,0,0,0));
        mem_ready_i = 1'b1;
        cyc("lui_fetch",   4'd0, fetch_go);
        cyc("lui_decode",  4'd1, decode_c);
        cyc("lui_exec",    4'd8, ctl(0,0,0,0,0,0,0,0,0,2,5,3,0,0));
        cyc("lui_wb",      4'd9, ctl(0,0,0,0,0,0,1,0,0,0,0,0,1,0));

        // ori
        op_i = 6'h0d;
        cyc("ori_fetch",   4'd0, fetch_go);
        cyc("ori_decode",  4'd1, decode_c);
        cyc("ori_exec",    4'd8, ctl(0,0,0,0,0,0,0,0,0,1,4,3,0,0));
        cyc("ori_wb",      4'd9, ctl(0,0,0,0,0,0,1,0,0,0,0,0,1,0));

        // Illegal opcode: TRAP for 10 cycles, then a reset pulse
        op_i = 6'h3f;
        cyc("trap_fetch",  4'd0, fetch_go);
        cyc("trap_decode", 4'd1, decode_c);
        for (int i = 0; i < 10; i++) begin
            cyc("trap_hold", 4'd14, ctl(0,0,0,0,0,0,0,0,0,0,0,0,0,1));
        end
        rst_i = 1'b1;
        cyc("trap_rst",    4'd14, z);
        rst_i = 1'b0;

        // Illegal R-type funct also traps
        op_i = 6'h00; funct_i = 6'h3f;
        cyc("badfn_fetch", 4'd0, fetch_go);
        cyc("badfn_decode",4'd1, decode_c);
        cyc("badfn_trap",  4'd14, ctl(0,0,0,0,0,0,0,0,0,0,0,0,0,1));
        rst_i = 1'b1;
        cyc("badfn_rst",   4'd14, z);
        rst_i = 1'b0;

        // sw stalled in MEM_WR, reset lands mid-write
        op_i = 6'h2b;
        cyc("sw_fetch",    4'd0, fetch_go);
        cyc("sw_decode",   4'd1, decode_c);
        cyc("sw_addr",     4'd2, ctl(0,0,0,0,0,0,0,0,0,1,2,0,0,0));
        mem_ready_i = 1'b0;
        cyc("sw_wr_w",     4'd5, ctl(0,0,1,0,1,0,0,0,0,0,0,0,0,0));
        rst_i = 1'b1;
        cyc("sw_rst",      4'd5, z);
        rst_i = 1'b0;
`ifdef MC_CTRL_PERF_EN
        check("perf_cycle_rst", cycle_cnt_o, 32'd0);
        check("perf_instr_rst", instr_cnt_o, 32'd0);
`endif

        // Clean sw after reset: 4 cycles, done on the ready cycle
        mem_ready_i = 1'b1;
        cyc("sw2_fetch",   4'd0, fetch_go);
        cyc("sw2_decode",  4'd1, decode_c);
        cyc("sw2_addr",    4'd2, ctl(0,0,0,0,0,0,0,0,0,1,2,0,0,0));
        cyc("sw2_wr",      4'd5, ctl(0,0,1,0,1,0,0,0,0,0,0,0,1,0));
        cyc("sw2_back",    4'd0, fetch_go);
`ifdef MC_CTRL_PERF_EN
        check("perf_cycle_run", cycle_cnt_o, 32'd5);
        check("perf_instr_run", instr_cnt_o, 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
